// File: rtl/usr_pkg.sv
// Shared mode codes, FSM states and helpers for the universal shift register.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Modes that move bits (and so may be run as a burst and update ser_out).
    function automatic logic is_shift_mode(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// One combinational step of the universal register, shared by the
// single-step and burst paths.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] next_q,
    output logic             shifted_out_bit
);

    always_comb begin
        next_q          = q;
        shifted_out_bit = 1'b0;
        case (mode)
            MODE_HOLD: next_q = q;
            MODE_LOAD: next_q = par_in;
            MODE_SHL: begin
                next_q          = {q[WIDTH-2:0], ser_in};
                shifted_out_bit = q[WIDTH-1];
            end
            MODE_SHR: begin
                next_q          = {ser_in, q[WIDTH-1:1]};
                shifted_out_bit = q[0];
            end
            MODE_ROL: begin
                next_q          = {q[WIDTH-2:0], q[WIDTH-1]};
                shifted_out_bit = q[WIDTH-1];
            end
            MODE_ROR: begin
                next_q          = {q[0], q[WIDTH-1:1]};
                shifted_out_bit = q[0];
            end
            MODE_ASR: begin
                next_q          = {q[WIDTH-1], q[WIDTH-1:1]};
                shifted_out_bit = q[0];
            end
            MODE_CLR: next_q = '0;
            default:  next_q = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: hold/load/shift/rotate/clear per cycle, plus an
// autonomous N-step burst engine with busy/done status.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CNT_W     = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             ser_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [2:0]       burst_mode;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] sat_cnt;
    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;

    assign sat_cnt   = (shift_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_cnt;
    assign step_mode = (state == ST_RUN) ? burst_mode : mode;
    assign q_not     = ~q;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q               (q),
        .mode            (step_mode),
        .ser_in          (ser_in),
        .par_in          (par_in),
        .next_q          (step_q),
        .shifted_out_bit (step_bit)
    );

    // A start with a non-shift mode falls through to the ordinary enable path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            q          <= RESET_VAL;
            ser_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            burst_mode <= MODE_HOLD;
            remaining  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && is_shift_mode(mode)) begin
                        burst_mode <= mode;
                        if (sat_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ST_RUN;
                            busy      <= 1'b1;
                            remaining <= sat_cnt;
                        end
                    end else if (enable) begin
                        q <= step_q;
                        if (is_shift_mode(mode)) begin
                            ser_out <= step_bit;
                        end
                    end
                end
                ST_RUN: begin
                    q         <= step_q;
                    ser_out   <= step_bit;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
